hazard_stall_ctrl: RTL and testbench

- Producer-side companion to the pipeline forwarding unit. Tracks, per pipeline stage, each in-flight destination register (A3) and its Tnew (cycles until its result is forwardable).
- Compares these against the Tuse of the instruction in D and asserts stall when forwarding cannot yet satisfy a source operand.
- Also owns the multiply/divide busy counter, and stalls HI/LO consumers while a mult/div is in progress.
- The E_A3, M_A3 and W_A3 outputs feed the forwarding unit directly.

---
 rtl/hazard_stall_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Producer-side hazard tracker for the 5-stage pipeline. Keeps the destination
// register (A3) and Tnew of the instructions in E, M and W, compares them with
// the Tuse of the D instruction, and raises stall when forwarding cannot yet
// deliver a source operand. Also owns the mult/div busy counter and stalls
// HI/LO consumers while it is nonzero.
// Optional build macro: HAZARD_PERF_CNT_EN adds a 32-bit stall-cycle counter
// on stall_count. When it is undefined, stall_count is tied to zero.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_A1,
    input  logic [4:0]  D_A2,
    input  logic [1:0]  D_Tuse_1,
    input  logic [1:0]  D_Tuse_2,
    input  logic [4:0]  D_A3,
    input  logic [1:0]  D_Tnew,
    input  logic        D_md_start,
    input  logic        D_md_div,
    input  logic        D_md_use,
    input  logic        req,
    output logic        stall,
    output logic [4:0]  E_A3,
    output logic [4:0]  M_A3,
    output logic [4:0]  W_A3,
    output logic        md_busy,
    output logic [31:0] stall_count
);

    localparam logic [CNT_W-1:0] LP_MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] LP_DIV_LOAD  = CNT_W'(DIV_CYCLES);

    // Pipeline tracking state
    logic [4:0]       r_e_a3;
    logic [1:0]       r_e_tnew;
    logic             r_e_md_start;
    logic             r_e_md_div;
    logic [4:0]       r_m_a3;
    logic [1:0]       r_m_tnew;
    logic [4:0]       r_w_a3;
    logic [CNT_W-1:0] r_md_cnt;

    logic             w_reg_hazard;
    logic             w_md_busy;
    logic             w_stall;

    // A source needs a stall when it is used, matches a nonzero in-flight
    // destination, and that result will not be ready by the time it is used.
    function automatic logic f_hazard(
        input logic [4:0] a,
        input logic [1:0] tuse,
        input logic [4:0] x_a3,
        input logic [1:0] x_tnew
    );
        return (tuse != 2'd3) && (a == x_a3) && (x_a3 != 5'd0) && (tuse < x_tnew);
    endfunction

    // Stall decision from current tracked state and the D instruction
    always_comb begin
        w_reg_hazard = f_hazard(D_A1, D_Tuse_1, r_e_a3, r_e_tnew) |
                       f_hazard(D_A1, D_Tuse_1, r_m_a3, r_m_tnew) |
                       f_hazard(D_A2, D_Tuse_2, r_e_a3, r_e_tnew) |
                       f_hazard(D_A2, D_Tuse_2, r_m_a3, r_m_tnew);
        w_md_busy    = (r_md_cnt != {CNT_W{1'b0}}) | r_e_md_start;
        if (D_md_use && w_md_busy) begin
            w_stall = 1'b1;
        end else begin
            w_stall = w_reg_hazard;
        end
    end

    // Advance the E/M/W tracking registers; flush on req, bubble E on stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e_a3       <= 5'd0;
            r_e_tnew     <= 2'd0;
            r_e_md_start <= 1'b0;
            r_e_md_div   <= 1'b0;
            r_m_a3       <= 5'd0;
            r_m_tnew     <= 2'd0;
            r_w_a3       <= 5'd0;
        end else if (req) begin
            r_e_a3       <= 5'd0;
            r_e_tnew     <= 2'd0;
            r_e_md_start <= 1'b0;
            r_e_md_div   <= 1'b0;
            r_m_a3       <= 5'd0;
            r_m_tnew     <= 2'd0;
            r_w_a3       <= 5'd0;
        end else begin
            if (w_stall) begin
                r_e_a3       <= 5'd0;
                r_e_tnew     <= 2'd0;
                r_e_md_start <= 1'b0;
                r_e_md_div   <= 1'b0;
            end else begin
                r_e_a3       <= D_A3;
                r_e_tnew     <= D_Tnew;
                r_e_md_start <= D_md_start;
                r_e_md_div   <= D_md_div;
            end
            r_m_a3   <= r_e_a3;
            r_m_tnew <= (r_e_tnew == 2'd0) ? 2'd0 : (r_e_tnew - 2'd1);
            r_w_a3   <= r_m_a3;
        end
    end

    // Mult/div busy counter; a flush does not cancel an operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_cnt <= {CNT_W{1'b0}};
        end else if (r_e_md_start) begin
            r_md_cnt <= r_e_md_div ? LP_DIV_LOAD : LP_MULT_LOAD;
        end else if (r_md_cnt != {CNT_W{1'b0}}) begin
            r_md_cnt <= r_md_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_md_cnt <= r_md_cnt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_count;

    // Count stalled cycles; wraps naturally, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_count <= 32'd0;
        end else if (w_stall) begin
            r_stall_count <= r_stall_count + 32'd1;
        end else begin
            r_stall_count <= r_stall_count;
        end
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = 32'd0;
`endif

    assign stall   = w_stall;
    assign md_busy = w_md_busy;
    assign E_A3    = r_e_a3;
    assign M_A3    = r_m_a3;
    assign W_A3    = r_w_a3;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl: table of per-cycle vectors plus
// hand-written sequences for div length, flush and mid-operation reset.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  D_A1 = 5'd0, D_A2 = 5'd0, D_A3 = 5'd0;
    logic [1:0]  D_Tuse_1 = 2'd3, D_Tuse_2 = 2'd3, D_Tnew = 2'd0;
    logic        D_md_start = 1'b0, D_md_div = 1'b0, D_md_use = 1'b0;
    logic        req = 1'b0;
    logic        stall, md_busy;
    logic [4:0]  E_A3, M_A3, W_A3;
    logic [31:0] stall_count;

    int checks = 0;
    int errors = 0;

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset),
        .D_A1(D_A1), .D_A2(D_A2), .D_Tuse_1(D_Tuse_1), .D_Tuse_2(D_Tuse_2),
        .D_A3(D_A3), .D_Tnew(D_Tnew), .D_md_start(D_md_start), .D_md_div(D_md_div),
        .D_md_use(D_md_use), .req(req),
        .stall(stall), .E_A3(E_A3), .M_A3(M_A3), .W_A3(W_A3),
        .md_busy(md_busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a1;
        logic [1:0] tu1;
        logic [4:0] a2;
        logic [1:0] tu2;
        logic [4:0] a3;
        logic [1:0] tnew;
        logic       mds, mdd, mdu;
        logic       exp_stall;
        logic [4:0] exp_e, exp_m, exp_w;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [4:0] a1, input logic [1:0] tu1,
        input logic [4:0] a2, input logic [1:0] tu2,
        input logic [4:0] a3, input logic [1:0] tnew,
        input logic mds, input logic mdd, input logic mdu,
        input logic est, input logic [4:0] ee, input logic [4:0] em,
        input logic [4:0] ew, input logic eb
    );
        vec_t v;
        v.a1 = a1; v.tu1 = tu1; v.a2 = a2; v.tu2 = tu2; v.a3 = a3; v.tnew = tnew;
        v.mds = mds; v.mdd = mdd; v.mdu = mdu;
        v.exp_stall = est; v.exp_e = ee; v.exp_m = em; v.exp_w = ew; v.exp_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] a1, input logic [1:0] tu1,
                         input logic [4:0] a2, input logic [1:0] tu2,
                         input logic [4:0] a3, input logic [1:0] tnew,
                         input logic mds, input logic mdd, input logic mdu);
        D_A1 = a1; D_Tuse_1 = tu1; D_A2 = a2; D_Tuse_2 = tu2;
        D_A3 = a3; D_Tnew = tnew; D_md_start = mds; D_md_div = mdd; D_md_use = mdu;
    endtask

    task automatic nop();
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        // lw $1 ; add using $1 (Tuse 1): one stall
        vecs.push_back(mk(5'd2, 2'd1, 5'd0, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0));
        vecs.push_back(mk(5'd1, 2'd1, 5'd3, 2'd1, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0));
        vecs.push_back(mk(5'd1, 2'd1, 5'd3, 2'd1, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd0, 1'b0));
        vecs.push_back(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 5'd0, 5'd1, 1'b0));
        vecs.push_back(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0, 1'b0));
        vecs.push_back(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4, 1'b0));
        // lw $1 ; beq on $1 (Tuse 0): two stalls, released when lw reaches W
        vecs.push_back(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0));
        vecs.push_back(mk(5'd1, 2'd0, 5'd5, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0));
        vecs.push_back(mk(5'd1, 2'd0, 5'd5, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd1, 5'd0, 1'b0));
        vecs.push_back(mk(5'd1, 2'd0, 5'd5, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b0));
        vecs.push_back(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0));
        // producer to $0 with Tnew 2, consumer of $0 with Tuse 0: no stall
        vecs.push_back(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0));
        vecs.push_back(mk(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0));
        // lw $6 ; unused-operand match (Tuse 3) ; rt hazard against ALU $7 in E
        vecs.push_back(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0));
        vecs.push_back(mk(5'd6, 2'd3, 5'd0, 2'd3, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6, 5'd0, 5'd0, 1'b0));
        vecs.push_back(mk(5'd0, 2'd3, 5'd7, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd6, 5'd0, 1'b0));
        vecs.push_back(mk(5'd0, 2'd3, 5'd7, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd6, 1'b0));
        vecs.push_back(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b0));
        vecs.push_back(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0));
        // mult immediately followed by mflo: six stalled cycles
        vecs.push_back(mk(5'd8, 2'd1, 5'd9, 2'd1, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1));
        vecs.push_back(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0));
        vecs.push_back(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 5'd0, 5'd0, 1'b0));
        vecs.push_back(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd10, 5'd0, 1'b0));
        vecs.push_back(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd10, 1'b0));

        // Reset state
        nop();
        #12;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_e_a3", 32'(E_A3), 32'd0);
        chk("rst_m_a3", 32'(M_A3), 32'd0);
        chk("rst_w_a3", 32'(W_A3), 32'd0);
        chk("rst_stall_count", stall_count, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven vectors, one per cycle
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].a1, vecs[i].tu1, vecs[i].a2, vecs[i].tu2, vecs[i].a3,
                  vecs[i].tnew, vecs[i].mds, vecs[i].mdd, vecs[i].mdu);
            #2;
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            chk($sformatf("v%0d_e_a3", i), 32'(E_A3), 32'(vecs[i].exp_e));
            chk($sformatf("v%0d_m_a3", i), 32'(M_A3), 32'(vecs[i].exp_m));
            chk($sformatf("v%0d_w_a3", i), 32'(W_A3), 32'(vecs[i].exp_w));
            chk($sformatf("v%0d_busy", i), 32'(md_busy), 32'(vecs[i].exp_busy));
        end

        // div followed immediately by mfhi: eleven stalled cycles
        @(negedge clk);
        drive(5'd8, 2'd1, 5'd9, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        #2;
        chk("div_issue_stall", 32'(stall), 32'd0);
        @(negedge clk);
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 2'd1, 1'b0, 1'b0, 1'b1);
        #2;
        n = 0;
        while (stall === 1'b1 && n < 30) begin
            n++;
            @(negedge clk);
            #2;
        end
        chk("div_stall_len", 32'(n), 32'd11);
        chk("div_busy_after", 32'(md_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nop();
        end

        // Flush while a lw $2 dependency stalls, with a mult counting down
        @(negedge clk);
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd2, 1'b0, 1'b0, 1'b0);
        #2;
        chk("req_lw_not_md_user", 32'(stall), 32'd0);
        @(negedge clk);
        drive(5'd2, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        req = 1'b1;
        #2;
        chk("req_pre_stall", 32'(stall), 32'd1);
        chk("req_pre_e_a3", 32'(E_A3), 32'd2);
        @(negedge clk);
        req = 1'b0;
        #2;
        chk("req_e_a3", 32'(E_A3), 32'd0);
        chk("req_m_a3", 32'(M_A3), 32'd0);
        chk("req_stall", 32'(stall), 32'd0);
        chk("req_busy_kept", 32'(md_busy), 32'd1);
        for (int i = 0; i < 3; i++) @(negedge clk);
        #2;
        chk("req_busy_last", 32'(md_busy), 32'd1);
        @(negedge clk);
        #2;
        chk("req_busy_done", 32'(md_busy), 32'd0);

        // Reset asserted mid-division (counter at 7)
        @(negedge clk);
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        #2;
        chk("mid_busy", 32'(md_busy), 32'd1);
        chk("mid_w_a3", 32'(W_A3), 32'd3);
        reset = 1'b0;
        #1;
        chk("arst_busy", 32'(md_busy), 32'd0);
        chk("arst_e_a3", 32'(E_A3), 32'd0);
        chk("arst_m_a3", 32'(M_A3), 32'd0);
        chk("arst_w_a3", 32'(W_A3), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_stall_count", stall_count, 32'd0);
        nop();
        @(negedge clk);
        reset = 1'b1;
        #2;
        chk("restart_busy", 32'(md_busy), 32'd0);

        // Three stalled cycles after restart: lw $4/beq $4 then lw $5/add $5
        @(negedge clk);
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd2, 1'b0, 1'b0, 1'b0);
        #2;
        chk("restart_stall", 32'(stall), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(5'd4, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
            #2;
            chk($sformatf("beq4_stall%0d", i), 32'(stall), (i < 2) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(5'd5, 2'd1, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
            #2;
            chk($sformatf("add5_stall%0d", i), 32'(stall), (i == 0) ? 32'd1 : 32'd0);
        end
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_after_3", stall_count, 32'd3);
`else
        chk("perf_tied_zero", stall_count, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
